seq_const_divider: RTL and testbench



---
 rtl/seq_const_divider.sv | 133 +++++++++++++
 tb/tb_seq_const_divider.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_const_divider.sv
// Bit-serial MSB-first divider by a compile-time constant, one remainder stage per clock.
// Handshake: start is accepted only while ready; done pulses once when the result lands.
module seq_const_divider #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIVISOR = 3,
    parameter int unsigned REM_W   = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [REM_W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned T_W   = REM_W + 1;

    localparam logic [T_W-1:0]   DIV_T    = T_W'(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Illegal parameterisations stop elaboration.
    if (DIVISOR < 2) begin : g_bad_divisor
        $error("seq_const_divider: DIVISOR must be >= 2");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("seq_const_divider: WIDTH must be >= 2");
    end
    if (REM_W != $clog2(DIVISOR)) begin : g_bad_rem_w
        $error("seq_const_divider: REM_W is derived and must not be overridden");
    end

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic [REM_W-1:0] r_q,         r_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [REM_W-1:0] remainder_q, remainder_d;
    logic             ready_q,     ready_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    // One shared remainder stage: bring down the next dividend bit, subtract if it fits.
    logic [T_W-1:0]   t_c;
    logic             qbit_c;
    logic [REM_W-1:0] r_next_c;

    always_comb begin
        t_c      = {r_q, shreg_q[WIDTH-1]};
        qbit_c   = (t_c >= DIV_T);
        r_next_c = qbit_c ? REM_W'(t_c - DIV_T) : REM_W'(t_c);
    end

    // The shift register holds the dividend; quotient bits enter at the LSB as it drains.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        r_d         = r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d = dividend;
                    r_d     = '0;
                    cnt_d   = CNT_INIT;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                shreg_d = {shreg_q[WIDTH-2:0], qbit_c};
                r_d     = r_next_c;
                if (cnt_q == '0) begin
                    quotient_d  = {shreg_q[WIDTH-2:0], qbit_c};
                    remainder_d = r_next_c;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            r_q         <= r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_const_divider.sv
// Directed bench for seq_const_divider: five divisors share one stimulus stream.
// Slots 0..4 correspond to DIVISOR 3, 5, 4, 2, 7.
module tb_seq_const_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;

    always #5 clk = ~clk;

    logic       ready_3, busy_3, done_3, ready_5, busy_5, done_5, ready_4, busy_4, done_4;
    logic       ready_2, busy_2, done_2, ready_7, busy_7, done_7;
    logic [7:0] q_3, q_5, q_4, q_2, q_7;
    logic [1:0] r_3, r_4;
    logic [2:0] r_5, r_7;
    logic [0:0] r_2;

    seq_const_divider #(.WIDTH(8), .DIVISOR(3)) u_d3 (.clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .ready(ready_3), .busy(busy_3), .done(done_3), .quotient(q_3), .remainder(r_3));
    seq_const_divider #(.WIDTH(8), .DIVISOR(5)) u_d5 (.clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .ready(ready_5), .busy(busy_5), .done(done_5), .quotient(q_5), .remainder(r_5));
    seq_const_divider #(.WIDTH(8), .DIVISOR(4)) u_d4 (.clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .ready(ready_4), .busy(busy_4), .done(done_4), .quotient(q_4), .remainder(r_4));
    seq_const_divider #(.WIDTH(8), .DIVISOR(2)) u_d2 (.clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .ready(ready_2), .busy(busy_2), .done(done_2), .quotient(q_2), .remainder(r_2));
    seq_const_divider #(.WIDTH(8), .DIVISOR(7)) u_d7 (.clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .ready(ready_7), .busy(busy_7), .done(done_7), .quotient(q_7), .remainder(r_7));

    logic [7:0] q_o   [5];
    logic [2:0] r_o   [5];
    logic       rdy_o [5];
    logic       bsy_o [5];
    logic       dn_o  [5];

    assign q_o[0] = q_3;  assign r_o[0] = 3'(r_3);  assign rdy_o[0] = ready_3;
    assign q_o[1] = q_5;  assign r_o[1] = r_5;      assign rdy_o[1] = ready_5;
    assign q_o[2] = q_4;  assign r_o[2] = 3'(r_4);  assign rdy_o[2] = ready_4;
    assign q_o[3] = q_2;  assign r_o[3] = 3'(r_2);  assign rdy_o[3] = ready_2;
    assign q_o[4] = q_7;  assign r_o[4] = r_7;      assign rdy_o[4] = ready_7;
    assign bsy_o[0] = busy_3; assign bsy_o[1] = busy_5; assign bsy_o[2] = busy_4;
    assign bsy_o[3] = busy_2; assign bsy_o[4] = busy_7;
    assign dn_o[0] = done_3;  assign dn_o[1] = done_5;  assign dn_o[2] = done_4;
    assign dn_o[3] = done_2;  assign dn_o[4] = done_7;

    int divs [5] = '{3, 5, 4, 2, 7};
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Every instance must show exactly one of ready/busy/done in every cycle after reset.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if ($countones({rdy_o[k], bsy_o[k], dn_o[k]}) != 1) begin
                    errors++;
                    $display("FAIL onehot div=%0d ready=%b busy=%b done=%b expected exactly one high",
                             divs[k], rdy_o[k], bsy_o[k], dn_o[k]);
                end
            end
        end
    end

    // Issue one operation from a falling edge; returns cycles from acceptance to done (30 = timed out).
    task automatic run_op(input logic [7:0] a, output int lat);
        int guard = 0;
        while (ready_3 !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        start    = 1'b1;
        dividend = a;
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        lat      = 1;
        while (done_3 !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rdy_o[k] !== 1'b1 || bsy_o[k] !== 1'b0 || dn_o[k] !== 1'b0 ||
                q_o[k] !== 8'd0 || r_o[k] !== 3'd0) begin
                errors++;
                $display("FAIL reset div=%0d got rdy=%b busy=%b done=%b q=%0d r=%0d expected 1 0 0 0 0",
                         divs[k], rdy_o[k], bsy_o[k], dn_o[k], q_o[k], r_o[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        int eq [5] = '{66, 40, 50, 100, 28};
        int er [5] = '{2, 0, 0, 0, 4};
        run_op(8'd200, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL basic_latency got %0d expected 9", lat);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (q_o[k] !== 8'(eq[k]) || r_o[k] !== 3'(er[k])) begin
                errors++;
                $display("FAIL basic_200 div=%0d got q=%0d r=%0d expected q=%0d r=%0d",
                         divs[k], q_o[k], r_o[k], eq[k], er[k]);
            end
        end
    endtask

    task automatic test_extremes();
        int lat;
        int eq [5] = '{85, 51, 63, 127, 36};
        int er [5] = '{0, 0, 3, 1, 3};
        run_op(8'd0, lat);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (q_o[k] !== 8'd0 || r_o[k] !== 3'd0) begin
                errors++;
                $display("FAIL zero div=%0d got q=%0d r=%0d expected q=0 r=0", divs[k], q_o[k], r_o[k]);
            end
        end
        run_op(8'd255, lat);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (q_o[k] !== 8'(eq[k]) || r_o[k] !== 3'(er[k])) begin
                errors++;
                $display("FAIL max_255 div=%0d got q=%0d r=%0d expected q=%0d r=%0d",
                         divs[k], q_o[k], r_o[k], eq[k], er[k]);
            end
        end
    endtask

    // The previous result (255) must stay on the ports while 251 is in flight.
    task automatic test_hold_during_run();
        int lat;
        int eq [5] = '{83, 50, 62, 125, 35};
        int er [5] = '{2, 1, 3, 1, 6};
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd251;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'd0;
        lat      = 1;
        repeat (3) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (busy_3 !== 1'b1 || q_3 !== 8'd85 || r_3 !== 2'd0 || q_7 !== 8'd36 || r_7 !== 3'd3) begin
            errors++;
            $display("FAIL hold_mid_run got busy=%b q3=%0d r3=%0d q7=%0d r7=%0d expected 1 85 0 36 3",
                     busy_3, q_3, r_3, q_7, r_7);
        end
        while (done_3 !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL hold_latency got %0d expected 9", lat);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (q_o[k] !== 8'(eq[k]) || r_o[k] !== 3'(er[k])) begin
                errors++;
                $display("FAIL val_251 div=%0d got q=%0d r=%0d expected q=%0d r=%0d",
                         divs[k], q_o[k], r_o[k], eq[k], er[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int guard = 0;
        int eq1 [5] = '{33, 20, 25, 50, 14};
        int er1 [5] = '{1, 0, 0, 0, 2};
        int eq2 [5] = '{2, 1, 1, 3, 1};
        int er2 [5] = '{1, 2, 3, 1, 0};
        while (ready_3 !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        start    = 1'b1;
        dividend = 8'd100;
        @(negedge clk);
        dividend = 8'd7;
        lat      = 1;
        while (done_3 !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL b2b_first_latency got %0d expected 9", lat);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (q_o[k] !== 8'(eq1[k]) || r_o[k] !== 3'(er1[k])) begin
                errors++;
                $display("FAIL b2b_first div=%0d got q=%0d r=%0d expected q=%0d r=%0d",
                         divs[k], q_o[k], r_o[k], eq1[k], er1[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (ready_3 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_after_done got %b expected 1", ready_3);
        end
        @(negedge clk);
        checks++;
        if (busy_3 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept got busy=%b expected 1", busy_3);
        end
        start = 1'b0;
        lat   = 1;
        while (done_3 !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL b2b_second_latency got %0d expected 9", lat);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (q_o[k] !== 8'(eq2[k]) || r_o[k] !== 3'(er2[k])) begin
                errors++;
                $display("FAIL b2b_second div=%0d got q=%0d r=%0d expected q=%0d r=%0d",
                         divs[k], q_o[k], r_o[k], eq2[k], er2[k]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit saw_done = 1'b0;
        int eq [5] = '{3, 1, 2, 4, 1};
        int er [5] = '{0, 4, 1, 1, 2};
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rdy_o[k] !== 1'b1 || dn_o[k] !== 1'b0 || q_o[k] !== 8'd0 || r_o[k] !== 3'd0) begin
                errors++;
                $display("FAIL midrun_reset div=%0d got rdy=%b done=%b q=%0d r=%0d expected 1 0 0 0",
                         divs[k], rdy_o[k], dn_o[k], q_o[k], r_o[k]);
            end
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done_3 === 1'b1 || done_7 === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done got done pulse=%b expected 0", saw_done);
        end
        run_op(8'd9, lat);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (q_o[k] !== 8'(eq[k]) || r_o[k] !== 3'(er[k])) begin
                errors++;
                $display("FAIL after_reset_9 div=%0d got q=%0d r=%0d expected q=%0d r=%0d",
                         divs[k], q_o[k], r_o[k], eq[k], er[k]);
            end
        end
    endtask

    task automatic test_sweep();
        int lat;
        for (int a = 0; a < 256; a++) begin
            run_op(8'(a), lat);
            checks++;
            if (lat !== 9) begin
                errors++;
                $display("FAIL sweep_latency a=%0d got %0d expected 9", a, lat);
            end
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (q_o[k] !== 8'(a / divs[k]) || r_o[k] !== 3'(a % divs[k])) begin
                    errors++;
                    $display("FAIL sweep a=%0d div=%0d got q=%0d r=%0d expected q=%0d r=%0d",
                             a, divs[k], q_o[k], r_o[k], a / divs[k], a % divs[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_hold_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
